// File: rtl/step_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : step_assembler_if
// Description : Word-in / step-out handshake bundle for step_assembler.
// Revision    : 1.0
// ============================================================================
interface step_assembler_if #(
    parameter int STEP_W = 560,
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [STEP_W-1:0] out_step;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_step
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_step
    );
endinterface
`default_nettype wire

// File: rtl/step_assembler.sv
`default_nettype none
// ============================================================================
// Module      : step_assembler
// Description : Reassembles 32-bit trace words into 560-bit steps for the
//               tiny86 checker, with framing checks and step/drop counters.
// Revision    : 1.0
// ============================================================================
module step_assembler #(
    parameter int STEP_W = 560,
    parameter int WORD_W = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    step_assembler_if.slave  bus,
    output logic [31:0]      step_count,
    output logic [15:0]      drop_count,
    output logic             frame_err
);

    localparam int c_beats  = (STEP_W + WORD_W - 1) / WORD_W;
    localparam int c_last_w = STEP_W - (c_beats - 1) * WORD_W;
    localparam int c_beat_w = $clog2(c_beats);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_FULL   = 2'd1,
        S_RESYNC = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_beat_w-1:0] r_beat;
    logic [c_beat_w-1:0] w_beat_next;

    logic [WORD_W-1:0]   r_fill [c_beats-1];
    logic [c_last_w-1:0] r_fill_last;
    logic [STEP_W-1:0]   w_fill_flat;
    logic [STEP_W-1:0]   w_step_direct;

    logic                r_in_ready;
    logic                r_out_valid;
    logic [STEP_W-1:0]   r_out_step;

    logic                w_accept;
    logic                w_out_xfer;
    logic                w_out_free;
    logic                w_pad_bad;
    logic                w_store;
    logic                w_load_direct;
    logic                w_load_fill;
    logic                w_drop;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_store    = w_accept && (r_state == S_FILL);

    generate
        for (genvar k = 0; k < c_beats - 1; k++) begin : g_flat
            assign w_fill_flat[k*WORD_W +: WORD_W] = r_fill[k];
        end
    endgenerate
    assign w_fill_flat[STEP_W-1 -: c_last_w] = r_fill_last;

    // Final beat bypasses the fill buffer so the step reaches the output one cycle after it arrives.
    assign w_step_direct = {bus.in_data[c_last_w-1:0], w_fill_flat[STEP_W-c_last_w-1:0]};

    generate
        if (c_last_w < WORD_W) begin : g_pad
            assign w_pad_bad = |bus.in_data[WORD_W-1:c_last_w];
        end else begin : g_no_pad
            assign w_pad_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_beat_next   = r_beat;
        w_load_direct = 1'b0;
        w_load_fill   = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (r_beat == c_last_beat) begin
                        w_beat_next = '0;
                        if (!bus.in_last) begin
                            w_drop       = 1'b1;
                            w_state_next = S_RESYNC;
                        end else if (w_pad_bad) begin
                            w_drop = 1'b1;
                        end else if (w_out_free) begin
                            w_load_direct = 1'b1;
                        end else begin
                            w_state_next = S_FULL;
                        end
                    end else if (bus.in_last) begin
                        w_drop      = 1'b1;
                        w_beat_next = '0;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (w_out_xfer) begin
                    w_load_fill  = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            S_RESYNC: begin
                if (w_accept && bus.in_last) begin
                    w_state_next = S_FILL;
                    w_beat_next  = '0;
                end
            end
            default: begin
                w_state_next = S_FILL;
                w_beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_beat      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_step  <= '0;
            r_fill_last <= '0;
            step_count  <= '0;
            drop_count  <= '0;
            frame_err   <= 1'b0;
            for (int k = 0; k < c_beats - 1; k++) begin
                r_fill[k] <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_beat     <= w_beat_next;
            r_in_ready <= (w_state_next != S_FULL);

            if (w_store) begin
                if (r_beat == c_last_beat) begin
                    r_fill_last <= bus.in_data[c_last_w-1:0];
                end else begin
                    r_fill[r_beat] <= bus.in_data;
                end
            end

            if (w_load_direct) begin
                r_out_step  <= w_step_direct;
                r_out_valid <= 1'b1;
            end else if (w_load_fill) begin
                r_out_step  <= w_fill_flat;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_xfer) begin
                step_count <= step_count + 32'd1;
            end

            if (w_drop) begin
                frame_err <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_step  = r_out_step;

endmodule
`default_nettype wire

// File: tb/tb_step_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_assembler
// Description : Directed vector table plus multi-cycle sequences for step_assembler.
// Revision    : 1.0
// ============================================================================
module tb_step_assembler;

    localparam int STEP_W = 560;
    localparam int WORD_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] step_count;
    logic [15:0] drop_count;
    logic        frame_err;

    step_assembler_if #(.STEP_W(STEP_W), .WORD_W(WORD_W)) bus ();

    step_assembler #(.STEP_W(STEP_W), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .step_count (step_count),
        .drop_count (drop_count),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cycle  = 0;

    logic [STEP_W-1:0] exp_q [$];
    logic [STEP_W-1:0] got_q [$];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_step);
        end
    end

    typedef struct {
        bit          rst_before;
        logic [31:0] base;
        int          nbeats;
        int          last_at;
        logic [15:0] pad;
        bit          deliver;
        logic [31:0] exp_steps;
        logic [15:0] exp_drop;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [STEP_W-1:0] model_step(input logic [31:0] base);
        logic [STEP_W-1:0] s;
        logic [31:0]       w;
        s = '0;
        for (int k = 0; k < 17; k++) begin
            w = base + 32'(k);
            s[k*32 +: 32] = w;
        end
        w = base + 32'd17;
        s[559:544] = w[15:0];
        return s;
    endfunction

    function automatic logic [31:0] beat_word(input logic [31:0] base, input int k,
                                              input logic [15:0] pad);
        logic [31:0] w;
        w = base + 32'(k);
        if (k == 17) w = {pad, w[15:0]};
        return w;
    endfunction

    task automatic chk_step(input string name, input logic [STEP_W-1:0] act,
                            input logic [STEP_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, output bit ok);
        int budget;
        budget = 200;
        ok = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1) begin
            @(posedge clk);
            #1;
            budget--;
            if (budget == 0) begin
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_vec++;
            n_fail++;
            $display("FAIL in_ready timeout: got 0 want 1 within 200 cycles");
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int nbeats, input int last_at,
                              input logic [15:0] pad);
        bit ok;
        for (int k = 0; k < nbeats; k++) begin
            send_word(beat_word(base, k, pad), (k == last_at), ok);
            if (!ok) return;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        wait_cycles(2);
        chk32("rst in_ready",   32'(bus.in_ready),  32'd0);
        chk32("rst out_valid",  32'(bus.out_valid), 32'd0);
        chk_step("rst out_step", bus.out_step, '0);
        chk32("rst step_count", step_count,         32'd0);
        chk32("rst drop_count", 32'(drop_count),    32'd0);
        chk32("rst frame_err",  32'(frame_err),     32'd0);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_sb(input string name);
        chk32({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk_step({name, " step"}, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        bit ok;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{1'b1, 32'h1000_0000, 18, 17, 16'h0000, 1'b1, 32'd1, 16'd0, 1'b0};
        vecs[1] = '{1'b0, 32'h2000_0000, 18, 17, 16'h0000, 1'b1, 32'd2, 16'd0, 1'b0};
        vecs[2] = '{1'b1, 32'h3000_0000,  6,  5, 16'h0000, 1'b0, 32'd0, 16'd1, 1'b1};
        vecs[3] = '{1'b0, 32'h4000_0000, 18, 17, 16'h0000, 1'b1, 32'd1, 16'd1, 1'b1};
        vecs[4] = '{1'b1, 32'h5000_0000, 21, 20, 16'h0000, 1'b0, 32'd0, 16'd1, 1'b1};
        vecs[5] = '{1'b0, 32'h6000_0000, 18, 17, 16'h0000, 1'b1, 32'd1, 16'd1, 1'b1};
        vecs[6] = '{1'b1, 32'h7000_0000, 18, 17, 16'hABCD, 1'b0, 32'd0, 16'd1, 1'b1};
        vecs[7] = '{1'b0, 32'h8000_0000, 18, 17, 16'h0000, 1'b1, 32'd1, 16'd1, 1'b1};
        vecs[8] = '{1'b1, 32'h9000_0000,  1,  0, 16'h0000, 1'b0, 32'd0, 16'd1, 1'b1};
        vecs[9] = '{1'b0, 32'hA000_0000, 18, 17, 16'h0000, 1'b1, 32'd1, 16'd1, 1'b1};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_before) do_reset();
            if (vecs[i].deliver) exp_q.push_back(model_step(vecs[i].base));
            send_frame(vecs[i].base, vecs[i].nbeats, vecs[i].last_at, vecs[i].pad);
            if (vecs[i].deliver) begin
                chk32("latency out_valid", 32'(bus.out_valid), 32'd1);
                chk_step("latency out_step", bus.out_step, model_step(vecs[i].base));
            end
            wait_cycles(4);
            chk32("step_count", step_count,         vecs[i].exp_steps);
            chk32("drop_count", 32'(drop_count),    32'(vecs[i].exp_drop));
            chk32("frame_err",  32'(frame_err),     32'(vecs[i].exp_err));
            chk32("idle out_valid", 32'(bus.out_valid), 32'd0);
            check_sb("vector sb");
        end

        // Two steps streamed back to back must take exactly 36 cycles.
        do_reset();
        wait_cycles(2);
        exp_q.push_back(model_step(32'h1111_0000));
        exp_q.push_back(model_step(32'h2222_0000));
        c0 = cycle;
        send_frame(32'h1111_0000, 18, 17, 16'h0000);
        send_frame(32'h2222_0000, 18, 17, 16'h0000);
        c1 = cycle;
        chk32("throughput cycles", 32'(c1 - c0), 32'd36);
        wait_cycles(4);
        chk32("throughput step_count", step_count, 32'd2);
        check_sb("throughput sb");

        // Three steps against a stalled consumer.
        do_reset();
        wait_cycles(2);
        exp_q.push_back(model_step(32'hB000_0000));
        exp_q.push_back(model_step(32'hC000_0000));
        exp_q.push_back(model_step(32'hD000_0000));
        bus.out_ready = 1'b0;
        fork
            begin
                send_frame(32'hB000_0000, 18, 17, 16'h0000);
                send_frame(32'hC000_0000, 18, 17, 16'h0000);
                send_frame(32'hD000_0000, 18, 17, 16'h0000);
            end
            begin
                wait_cycles(20);
                chk_step("held out_step early", bus.out_step, model_step(32'hB000_0000));
                wait_cycles(20);
                chk_step("held out_step late", bus.out_step, model_step(32'hB000_0000));
                chk32("bp in_ready",   32'(bus.in_ready),  32'd0);
                chk32("bp out_valid",  32'(bus.out_valid), 32'd1);
                chk32("bp step_count", step_count,         32'd0);
                bus.out_ready = 1'b1;
            end
        join
        wait_cycles(4);
        chk32("bp final step_count", step_count, 32'd3);
        chk32("bp drop_count", 32'(drop_count), 32'd0);
        check_sb("backpressure sb");

        // Reset in the middle of a step discards the partial data.
        for (int k = 0; k < 9; k++) begin
            send_word(beat_word(32'hE000_0000, k, 16'h0000), 1'b0, ok);
        end
        do_reset();
        wait_cycles(2);
        exp_q.push_back(model_step(32'hF000_0000));
        send_frame(32'hF000_0000, 18, 17, 16'h0000);
        wait_cycles(4);
        chk32("midrst step_count", step_count, 32'd1);
        chk32("midrst drop_count", 32'(drop_count), 32'd0);
        chk32("midrst frame_err",  32'(frame_err),  32'd0);
        check_sb("midreset sb");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
